tl_debug_unit: RTL

- Parametrised pipeline controller and observer that sits beside the five-stage MIPS top.
- Gates pipeline advance through a single enable and supports three modes: continuous run, single step and dump-only.
- After each step, on halt, or on request, it snapshots the four inter-stage latch buses plus a cycle counter.
- It streams the snapshot LSB-byte-first over a valid/ready byte interface toward the UART transmitter.

---
 rtl/tl_debug_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/tl_debug_unit.sv
// rtl/tl_debug_unit.sv - pipeline run/step controller with latch snapshot byte streamer
module tl_debug_unit #(
  parameter int NB_IF_ID  = 64,
  parameter int NB_ID_EX  = 192,
  parameter int NB_EX_MEM = 128,
  parameter int NB_MEM_WB = 64,
  parameter int NB_CYCLE  = 32,
  parameter int NB_DATA   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_DATA-1:0]   i_cmd,
  input  logic                 i_cmd_valid,
  input  logic [NB_IF_ID-1:0]  i_if_id,
  input  logic [NB_ID_EX-1:0]  i_id_ex,
  input  logic [NB_EX_MEM-1:0] i_ex_mem,
  input  logic [NB_MEM_WB-1:0] i_mem_wb,
  input  logic                 i_halt,
  input  logic                 i_tx_ready,
  output logic                 o_pipe_en,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_valid,
  output logic [2:0]           o_state,
  output logic [NB_CYCLE-1:0]  o_cycle_count,
  output logic                 o_halted
);

  localparam int NB_SNAP = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_CYCLE;
  localparam int NBYTES  = (NB_SNAP + NB_DATA - 1) / NB_DATA;
  localparam int NB_BUF  = NBYTES * NB_DATA;
  localparam int NB_IDX  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [NB_DATA-1:0] CMD_RUN  = NB_DATA'(8'h52);
  localparam logic [NB_DATA-1:0] CMD_STEP = NB_DATA'(8'h53);
  localparam logic [NB_DATA-1:0] CMD_DUMP = NB_DATA'(8'h44);
  localparam logic [NB_IDX-1:0]  LAST_IDX = NB_IDX'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    CAPTURE = 3'd3,
    DUMP    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [NB_IDX-1:0]   byte_idx;
  logic [NB_BUF-1:0]   snapshot;
  logic                last_xfer;

  assign last_xfer = (state == DUMP) && i_tx_ready && (byte_idx == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd == CMD_RUN)       state_next = RUN;
          else if (i_cmd == CMD_STEP) state_next = STEP;
          else if (i_cmd == CMD_DUMP) state_next = CAPTURE;
        end
      end
      RUN:     if (i_halt) state_next = CAPTURE;
      STEP:    state_next = CAPTURE;
      CAPTURE: state_next = DUMP;
      DUMP:    if (last_xfer) state_next = o_halted ? DONE : IDLE;
      DONE:    if (i_cmd_valid && (i_cmd == CMD_DUMP)) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  // The capture edge follows the last advancing edge, so the buses already hold its results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cycle_count <= '0;
      o_halted      <= 1'b0;
      byte_idx      <= '0;
      snapshot      <= '0;
    end else begin
      if (o_pipe_en) o_cycle_count <= o_cycle_count + 1'b1;
      if (o_pipe_en && i_halt) o_halted <= 1'b1;
      if (state == CAPTURE) begin
        snapshot <= NB_BUF'({o_cycle_count, i_mem_wb, i_ex_mem, i_id_ex, i_if_id});
        byte_idx <= '0;
      end else if ((state == DUMP) && i_tx_ready && (byte_idx != LAST_IDX)) begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  assign o_pipe_en  = (state == RUN) || (state == STEP);
  assign o_tx_valid = (state == DUMP);
  assign o_tx_data  = o_tx_valid ? snapshot[byte_idx*NB_DATA +: NB_DATA] : '0;
  assign o_state    = state;

endmodule
